// File: rtl/stream_fork_pkg.sv
// Shared types and constants for the two-branch stream fork.
package stream_fork_pkg;
    localparam int buf_depth = 2;
    typedef logic [1:0] cnt_t;
    typedef logic [15:0] stat_t;
endpackage

// File: rtl/stream_fork_branch_buffer.sv
// Two-entry FIFO buffer used for one downstream branch of the fork.
module stream_fork_branch_buffer
    import stream_fork_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [width-1:0] dout
);
    logic [width-1:0] mem [buf_depth];
    logic             wr_ptr;
    logic             rd_ptr;
    cnt_t             cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == cnt_t'(buf_depth));
    assign empty   = (cnt == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            for (int i = 0; i < buf_depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/stream_fork_using_double_buffers.sv
// Duplicates stream x into independently-flowing branches a and b.
// Optional per-branch transfer counters: define STREAM_FORK_STATS_EN.
module stream_fork_using_double_buffers
    import stream_fork_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [width-1:0] x_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [width-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [width-1:0] b_data
`ifdef STREAM_FORK_STATS_EN
    ,
    output stat_t            a_count,
    output stat_t            b_count
`endif
);
    logic ready_q;
    logic full_a;
    logic full_b;
    logic empty_a;
    logic empty_b;
    logic push;
    logic pop_a;
    logic pop_b;

    // ready_q keeps x_ready low while in reset, without any path from rst_n
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign x_ready = ready_q & ~full_a & ~full_b;
    assign push    = x_valid & x_ready;
    assign a_valid = ~empty_a;
    assign b_valid = ~empty_b;
    assign pop_a   = a_valid & a_ready;
    assign pop_b   = b_valid & b_ready;

    stream_fork_branch_buffer #(.width(width)) u_buf_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (x_data),
        .pop   (pop_a),
        .full  (full_a),
        .empty (empty_a),
        .dout  (a_data)
    );

    stream_fork_branch_buffer #(.width(width)) u_buf_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (x_data),
        .pop   (pop_b),
        .full  (full_b),
        .empty (empty_b),
        .dout  (b_data)
    );

`ifdef STREAM_FORK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (pop_a && (a_count != 16'hFFFF)) begin
                a_count <= a_count + 16'd1;
            end
            if (pop_b && (b_count != 16'hFFFF)) begin
                b_count <= b_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_fork_using_double_buffers.sv
// Directed and random checks of the two-branch stream fork.
module tb_stream_fork_using_double_buffers;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         x_valid = 1'b0;
    logic         a_ready = 1'b0;
    logic         b_ready = 1'b0;
    logic [W-1:0] x_data = '0;
    logic         x_ready;
    logic         a_valid;
    logic         b_valid;
    logic [W-1:0] a_data;
    logic [W-1:0] b_data;
`ifdef STREAM_FORK_STATS_EN
    logic [15:0]  a_count;
    logic [15:0]  b_count;
`endif

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [W-1:0] x_sent[$];
    logic [W-1:0] a_got[$];
    logic [W-1:0] b_got[$];
    int a_cyc[$];

    stream_fork_using_double_buffers #(.width(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_data  (x_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data)
`ifdef STREAM_FORK_STATS_EN
        ,
        .a_count (a_count),
        .b_count (b_count)
`endif
    );

    always #5 clk = ~clk;

    // transfer monitor: records every handshake seen at a rising edge
    always @(posedge clk) begin
        if (rst_n) begin
            cyc <= cyc + 1;
            if (x_valid && x_ready) x_sent.push_back(x_data);
            if (a_valid && a_ready) begin
                a_got.push_back(a_data);
                a_cyc.push_back(cyc);
            end
            if (b_valid && b_ready) b_got.push_back(b_data);
        end
    end

    function automatic logic [31:0] packq(input logic [W-1:0] q[$]);
        logic [31:0] r = '0;
        foreach (q[i]) r = {r[27:0], q[i]};
        return r;
    endfunction

    task automatic clear_q();
        x_sent.delete();
        a_got.delete();
        b_got.delete();
        a_cyc.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        compared++;
        if (x_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_x_ready got %b want 0", x_ready);
        end
        compared++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid got a=%b b=%b want 0 0", a_valid, b_valid);
        end
        compared++;
        if (a_data !== 4'h0 || b_data !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_data got a=%h b=%h want 0 0", a_data, b_data);
        end
`ifdef STREAM_FORK_STATS_EN
        compared++;
        if (a_count !== 16'd0 || b_count !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_stats got a=%0d b=%0d want 0 0", a_count, b_count);
        end
`endif
        rst_n = 1'b1;
        idle(1);
        compared++;
        if (x_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL release_x_ready got %b want 1", x_ready);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        clear_q();
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x_valid = 1'b1;
            x_data = W'(i + 1);
            compared++;
            if (x_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL b2b_x_ready step %0d got %b want 1", i, x_ready);
            end
            @(negedge clk);
        end
        x_valid = 1'b0;
        idle(3);
        compared++;
        if (a_got.size() != 20 || b_got.size() != 20) begin
            mismatched++;
            $display("FAIL b2b_count got a=%0d b=%0d want 20 20", a_got.size(), b_got.size());
        end
        for (int i = 0; i < a_got.size() && i < b_got.size(); i++) begin
            if (a_got[i] !== W'(i + 1) || b_got[i] !== W'(i + 1)) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL b2b_order got %0d bad items want 0", bad);
        end
        compared++;
        if (a_cyc.size() != 20 || (a_cyc[19] - a_cyc[0]) != 19) begin
            mismatched++;
            $display("FAIL b2b_rate got span %0d want 19", a_cyc.size() == 20 ? a_cyc[19] - a_cyc[0] : -1);
        end
    endtask

    task automatic test_stalled(input bit stall_a);
        logic [W-1:0] held;
        clear_q();
        a_ready = ~stall_a;
        b_ready = stall_a;
        x_valid = 1'b1;
        x_data = 4'd1;
        @(negedge clk);
        x_data = 4'd2;
        @(negedge clk);
        x_data = 4'd3;
        for (int i = 0; i < 3; i++) begin
            held = stall_a ? a_data : b_data;
            compared++;
            if (x_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL stall%s_x_ready got %b want 0", stall_a ? "a" : "b", x_ready);
            end
            compared++;
            if ((stall_a ? a_valid : b_valid) !== 1'b1 || held !== 4'd1) begin
                mismatched++;
                $display("FAIL stall%s_hold got data %h want 1", stall_a ? "a" : "b", held);
            end
            @(negedge clk);
        end
        compared++;
        if (packq(stall_a ? b_got : a_got) !== 32'h12 || x_sent.size() != 2) begin
            mismatched++;
            $display("FAIL stall%s_free got %h sent %0d want 12 sent 2", stall_a ? "a" : "b",
                     packq(stall_a ? b_got : a_got), x_sent.size());
        end
        a_ready = 1'b1;
        b_ready = 1'b1;
        idle(2);
        x_valid = 1'b0;
        idle(3);
        compared++;
        if (packq(a_got) !== 32'h123 || packq(b_got) !== 32'h123 || packq(x_sent) !== 32'h123) begin
            mismatched++;
            $display("FAIL stall%s_release got a=%h b=%h x=%h want 123", stall_a ? "a" : "b",
                     packq(a_got), packq(b_got), packq(x_sent));
        end
    endtask

    task automatic test_both_backpressured();
        clear_q();
        a_ready = 1'b0;
        b_ready = 1'b0;
        x_valid = 1'b1;
        x_data = 4'd5;
        @(negedge clk);
        x_data = 4'd6;
        @(negedge clk);
        x_data = 4'd7;
        idle(3);
        compared++;
        if (x_ready !== 1'b0 || packq(x_sent) !== 32'h56) begin
            mismatched++;
            $display("FAIL bp_accept got ready=%b x=%h want 0 56", x_ready, packq(x_sent));
        end
        x_valid = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        idle(4);
        compared++;
        if (packq(a_got) !== 32'h56 || packq(b_got) !== 32'h56) begin
            mismatched++;
            $display("FAIL bp_drain got a=%h b=%h want 56 56", packq(a_got), packq(b_got));
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        a_ready = 1'b0;
        b_ready = 1'b1;
        x_valid = 1'b1;
        x_data = 4'd9;
        @(negedge clk);
        x_data = 4'd10;
        @(negedge clk);
        x_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0 || x_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_flush got a=%b b=%b xr=%b want 0 0 0", a_valid, b_valid, x_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        compared++;
        if (x_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL midrst_ready got %b want 1", x_ready);
        end
        a_ready = 1'b1;
        x_valid = 1'b1;
        x_data = 4'd11;
        @(negedge clk);
        x_valid = 1'b0;
        idle(3);
        compared++;
        if (packq(a_got) !== 32'hB || packq(b_got) !== 32'hB || a_got.size() != 1) begin
            mismatched++;
            $display("FAIL midrst_item got a=%h b=%h want b b", packq(a_got), packq(b_got));
        end
    endtask

    task automatic test_random();
        int issued = 0;
        int prev = 0;
        int budget = 0;
        int bad = 0;
        x_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        while ((a_got.size() < 100 || b_got.size() < 100) && budget < 4000) begin
            if (x_valid && x_sent.size() > prev) x_valid = 1'b0;
            prev = x_sent.size();
            if (!x_valid && issued < 100 && $urandom_range(0, 3) != 0) begin
                x_valid = 1'b1;
                x_data = W'($urandom);
                issued++;
            end
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget++;
        end
        x_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        idle(2);
        compared++;
        if (budget >= 4000) begin
            mismatched++;
            $display("FAIL rand_timeout got a=%0d b=%0d items want 100", a_got.size(), b_got.size());
        end
        compared++;
        if (a_got.size() != 100 || b_got.size() != 100 || x_sent.size() != 100) begin
            mismatched++;
            $display("FAIL rand_count got a=%0d b=%0d x=%0d want 100", a_got.size(), b_got.size(),
                     x_sent.size());
        end
        for (int i = 0; i < x_sent.size(); i++) begin
            if (i >= a_got.size() || i >= b_got.size()) bad++;
            else if (a_got[i] !== x_sent[i] || b_got[i] !== x_sent[i]) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL rand_order got %0d bad items want 0", bad);
        end
`ifdef STREAM_FORK_STATS_EN
        compared++;
        if (a_count !== 16'd100 || b_count !== 16'd100) begin
            mismatched++;
            $display("FAIL rand_stats got a=%0d b=%0d want 100 100", a_count, b_count);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_stalled(1'b1);
        test_stalled(1'b0);
        test_both_backpressured();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
